// File: rtl/fb_sram_port.sv
// Framebuffer port onto a 16-bit asynchronous SRAM; every 32-bit access is split into a low and a high halfword cycle.
// Define FB_SRAM_WRITE_EN to enable writes; without it writes are accepted and silently dropped.
module fb_sram_port #(
    parameter int SRAM_AW = 18
) (
    input  logic               clk25MHz,
    input  logic               reset,
    input  logic               fb_transfer_request,
    input  logic [31:0]        fb_address,
    input  logic               fb_wren,
    input  logic [31:0]        fb_wrdata,
    input  logic [3:0]         fb_wrmask,
    output logic               fb_wait_request,
    output logic               fb_read_data_valid,
    output logic [31:0]        fb_read_data,
    output logic [SRAM_AW-1:0] sram_a,
    input  logic [15:0]        sram_d_in,
    output logic [15:0]        sram_d_out,
    output logic               sram_d_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2
`ifdef FB_SRAM_WRITE_EN
        ,
        WR_LO = 3'd3,
        WR_HI = 3'd4
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [SRAM_AW-1:0] sram_a_q, sram_a_d;
    logic [15:0]        rd_lo_q, rd_lo_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               lb_n_q, lb_n_d;
    logic               ub_n_q, ub_n_d;
    logic               busy;
    logic               accept;

`ifdef FB_SRAM_WRITE_EN
    logic               we_n_q, we_n_d;
    logic               d_oe_q, d_oe_d;
    logic [15:0]        d_out_q, d_out_d;
    logic [15:0]        wr_hi_q, wr_hi_d;
    logic [1:0]         wr_hi_mask_q, wr_hi_mask_d;

    assign busy = (state_q == RD_LO) || (state_q == WR_LO);
`else
    logic               unused_wr;

    assign unused_wr = ^{fb_wrdata, fb_wrmask};
    assign busy      = (state_q == RD_LO);
`endif

    // Address bits outside the SRAM word range simply alias; they are never flagged.
    logic unused_addr;
    assign unused_addr = ^{fb_address[31:SRAM_AW+1], fb_address[1:0]};

    assign accept = fb_transfer_request && !busy;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = IDLE;
        if (state_q == RD_LO) begin
            state_d = RD_HI;
`ifdef FB_SRAM_WRITE_EN
        end else if (state_q == WR_LO) begin
            state_d = WR_HI;
        end else if (accept) begin
            state_d = fb_wren ? WR_LO : RD_LO;
`else
        end else if (accept && !fb_wren) begin
            state_d = RD_LO;
`endif
        end
    end

    always_comb begin
        sram_a_d = sram_a_q;
        if (busy) begin
            sram_a_d = {sram_a_q[SRAM_AW-1:1], 1'b1};
        end else if (accept) begin
            sram_a_d = {fb_address[SRAM_AW:2], 1'b0};
        end
        rd_lo_d    = (state_q == RD_LO) ? sram_d_in : rd_lo_q;
        rd_valid_d = (state_q == RD_HI);
        rd_data_d  = (state_q == RD_HI) ? {sram_d_in, rd_lo_q} : rd_data_q;
    end

    // Strobes are registered, so they are decoded from the state being entered.
    always_comb begin
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        lb_n_d = 1'b1;
        ub_n_d = 1'b1;
`ifdef FB_SRAM_WRITE_EN
        we_n_d       = 1'b1;
        d_oe_d       = 1'b0;
        d_out_d      = d_out_q;
        wr_hi_d      = wr_hi_q;
        wr_hi_mask_d = wr_hi_mask_q;
        if (accept) begin
            wr_hi_d      = fb_wrdata[31:16];
            wr_hi_mask_d = fb_wrmask[3:2];
        end
`endif
        case (state_d)
            RD_LO, RD_HI: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
`ifdef FB_SRAM_WRITE_EN
            WR_LO: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                d_oe_d  = 1'b1;
                lb_n_d  = ~fb_wrmask[0];
                ub_n_d  = ~fb_wrmask[1];
                d_out_d = fb_wrdata[15:0];
            end
            WR_HI: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                d_oe_d  = 1'b1;
                lb_n_d  = ~wr_hi_mask_q[0];
                ub_n_d  = ~wr_hi_mask_q[1];
                d_out_d = wr_hi_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            state_q    <= IDLE;
            sram_a_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
`ifdef FB_SRAM_WRITE_EN
            we_n_q     <= 1'b1;
            d_oe_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sram_a_q   <= sram_a_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            lb_n_q     <= lb_n_d;
            ub_n_q     <= ub_n_d;
`ifdef FB_SRAM_WRITE_EN
            we_n_q     <= we_n_d;
            d_oe_q     <= d_oe_d;
`endif
        end
        // NOTE: pure datapath registers are not reset; each is loaded before anything observes it.
        rd_lo_q <= rd_lo_d;
`ifdef FB_SRAM_WRITE_EN
        d_out_q      <= d_out_d;
        wr_hi_q      <= wr_hi_d;
        wr_hi_mask_q <= wr_hi_mask_d;
`endif
    end

    assign fb_wait_request    = busy;
    assign fb_read_data_valid = rd_valid_q;
    assign fb_read_data       = rd_data_q;
    assign sram_a             = sram_a_q;
    assign sram_ce_n          = ce_n_q;
    assign sram_oe_n          = oe_n_q;
    assign sram_lb_n          = lb_n_q;
    assign sram_ub_n          = ub_n_q;
`ifdef FB_SRAM_WRITE_EN
    assign sram_we_n          = we_n_q;
    assign sram_d_oe          = d_oe_q;
    assign sram_d_out         = d_out_q;
`else
    assign sram_we_n          = 1'b1;
    assign sram_d_oe          = 1'b0;
    assign sram_d_out         = '0;
`endif

endmodule

// File: tb/tb_fb_sram_port.sv
// Bench for fb_sram_port: halfword SRAM pad model, word-level reference memory with a cycle scoreboard,
// and directed scenarios with literal expectations. Honours FB_SRAM_WRITE_EN the same way the design does.
module tb_fb_sram_port;
    localparam int AW = 18;

    logic          clk25MHz = 1'b0;
    logic          reset;
    logic          fb_transfer_request;
    logic [31:0]   fb_address;
    logic          fb_wren;
    logic [31:0]   fb_wrdata;
    logic [3:0]    fb_wrmask;
    logic          fb_wait_request;
    logic          fb_read_data_valid;
    logic [31:0]   fb_read_data;
    logic [AW-1:0] sram_a;
    logic [15:0]   sram_d_in;
    logic [15:0]   sram_d_out;
    logic          sram_d_oe;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    fb_sram_port #(.SRAM_AW(AW)) dut (
        .clk25MHz            (clk25MHz),
        .reset               (reset),
        .fb_transfer_request (fb_transfer_request),
        .fb_address          (fb_address),
        .fb_wren             (fb_wren),
        .fb_wrdata           (fb_wrdata),
        .fb_wrmask           (fb_wrmask),
        .fb_wait_request     (fb_wait_request),
        .fb_read_data_valid  (fb_read_data_valid),
        .fb_read_data        (fb_read_data),
        .sram_a              (sram_a),
        .sram_d_in           (sram_d_in),
        .sram_d_out          (sram_d_out),
        .sram_d_oe           (sram_d_oe),
        .sram_ce_n           (sram_ce_n),
        .sram_oe_n           (sram_oe_n),
        .sram_we_n           (sram_we_n),
        .sram_lb_n           (sram_lb_n),
        .sram_ub_n           (sram_ub_n)
    );

    always #20 clk25MHz = ~clk25MHz;

    int cyc = 0;
    always @(posedge clk25MHz) cyc <= cyc + 1;

    // Asynchronous SRAM pad model: combinational read, byte-lane write mid-cycle.
    logic [15:0] sram_mem [0:(1<<AW)-1];
    assign sram_d_in = sram_mem[sram_a];

    always @(negedge clk25MHz) begin
        if (!sram_ce_n && !sram_we_n && sram_d_oe) begin
            if (!sram_lb_n) sram_mem[sram_a][7:0]  <= sram_d_out[7:0];
            if (!sram_ub_n) sram_mem[sram_a][15:8] <= sram_d_out[15:8];
        end
    end

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic          lb_n;
        logic          ub_n;
    } bus_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_t;

    bus_t        exp_bus  [int];
    bit          exp_wait [int];
    rd_t         rdq[$];
    rd_t         vlog[$];
    logic [31:0] ref_mem  [int];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] bg(input int h);
        return h[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [31:0] ref_rd(input int wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return {bg(2 * wa + 1), bg(2 * wa)};
    endfunction

    task automatic preset(input int wa, input logic [31:0] v);
        sram_mem[2 * wa]     <= v[15:0];
        sram_mem[2 * wa + 1] <= v[31:16];
        ref_mem[wa] = v;
    endtask

    task automatic cancel_after(input int m);
        int  keys[$];
        rd_t keep[$];
        foreach (exp_bus[k])  if (k > m) keys.push_back(k);
        foreach (keys[i])     exp_bus.delete(keys[i]);
        keys.delete();
        foreach (exp_wait[k]) if (k > m) keys.push_back(k);
        foreach (keys[i])     exp_wait.delete(keys[i]);
        foreach (rdq[i])      if (rdq[i].cyc <= m) keep.push_back(rdq[i]);
        rdq = keep;
    endtask

    // Scoreboard: an accepted read owns the bus for the next two cycles and returns its word on the third;
    // an accepted write (when enabled) owns the bus for the next two cycles.
    task automatic monitor_cycle();
        bus_t          e;
        rd_t           r;
        bit            ev;
        int            wa;
        logic [AW-1:0] ha;
        logic [31:0]   w;
        check("wait_request", fb_wait_request, exp_wait.exists(cyc));
        if (exp_bus.exists(cyc)) begin
            e = exp_bus[cyc];
            check("sram_a", sram_a, e.a);
            check("sram_ce_n", sram_ce_n, 1'b0);
            check("sram_we_n", sram_we_n, e.wr ? 1'b0 : 1'b1);
            check("sram_oe_n", sram_oe_n, e.wr ? 1'b1 : 1'b0);
            check("sram_d_oe", sram_d_oe, e.wr);
            check("sram_lb_n", sram_lb_n, e.lb_n);
            check("sram_ub_n", sram_ub_n, e.ub_n);
            if (e.wr) check("sram_d_out", sram_d_out, e.d);
        end else begin
            check("idle_ce_n", sram_ce_n, 1'b1);
            check("idle_we_n", sram_we_n, 1'b1);
            check("idle_d_oe", sram_d_oe, 1'b0);
        end
        ev = (rdq.size() != 0) && (rdq[0].cyc == cyc);
        check("read_valid", fb_read_data_valid, ev);
        if (fb_read_data_valid) vlog.push_back('{cyc, fb_read_data});
        if (ev) begin
            r = rdq.pop_front();
            if (fb_read_data_valid) check("read_data", fb_read_data, r.data);
        end
        if (reset) begin
            cancel_after(cyc);
        end else if (fb_transfer_request && !fb_wait_request) begin
            wa = int'(fb_address[AW:2]);
            ha = AW'(wa * 2);
            if (!fb_wren) begin
                exp_wait[cyc + 1] = 1'b1;
                exp_bus[cyc + 1]  = '{1'b0, ha, 16'h0, 1'b0, 1'b0};
                exp_bus[cyc + 2]  = '{1'b0, ha + 1'b1, 16'h0, 1'b0, 1'b0};
                rdq.push_back('{cyc + 3, ref_rd(wa)});
            end else begin
`ifdef FB_SRAM_WRITE_EN
                exp_wait[cyc + 1] = 1'b1;
                exp_bus[cyc + 1]  = '{1'b1, ha, fb_wrdata[15:0], !fb_wrmask[0], !fb_wrmask[1]};
                exp_bus[cyc + 2]  = '{1'b1, ha + 1'b1, fb_wrdata[31:16], !fb_wrmask[2], !fb_wrmask[3]};
                w = ref_rd(wa);
                for (int b = 0; b < 4; b++) if (fb_wrmask[b]) w[8*b +: 8] = fb_wrdata[8*b +: 8];
                ref_mem[wa] = w;
`endif
            end
        end
    endtask

    always @(negedge clk25MHz) begin
        if (mon_en) monitor_cycle();
    end

    task automatic step();
        @(posedge clk25MHz);
        #1;
    endtask

    task automatic neg_at(input int c);
        int g = 0;
        do begin
            @(negedge clk25MHz);
            g++;
        end while (cyc < c && g < 100);
    endtask

    // Drives a request and returns (just after the accepting edge) with the request still raised.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, output int acc);
        bit ok = 1'b0;
        fb_transfer_request = 1'b1;
        fb_wren   = wr;
        fb_address = addr;
        fb_wrdata = data;
        fb_wrmask = mask;
        acc = -1;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk25MHz);
            if (!fb_wait_request) begin
                ok  = 1'b1;
                acc = cyc;
            end
        end
        if (!ok) check("accept_timeout", fb_wait_request, 1'b0);
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, fb_read_data_valid, 1'b0);
        check({tag, "_data"},  fb_read_data, 32'h0);
        check({tag, "_a"},     sram_a, 18'h0);
        check({tag, "_d_oe"},  sram_d_oe, 1'b0);
        check({tag, "_ce_n"},  sram_ce_n, 1'b1);
        check({tag, "_oe_n"},  sram_oe_n, 1'b1);
        check({tag, "_we_n"},  sram_we_n, 1'b1);
        check({tag, "_lb_n"},  sram_lb_n, 1'b1);
        check({tag, "_ub_n"},  sram_ub_n, 1'b1);
        check({tag, "_wait"},  fb_wait_request, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          a, a0, a1, a2, a3, n0;
        logic [31:0] exp4 [4];
        logic [31:0] exp_wr;

        reset = 1'b1;
        fb_transfer_request = 1'b0;
        fb_address = '0;
        fb_wren    = 1'b0;
        fb_wrdata  = '0;
        fb_wrmask  = '0;
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= bg(i);
        repeat (3) @(posedge clk25MHz);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk25MHz);
        check_reset_vals("por");
        step();

        // Single read of word 0x10: halfwords 8 then 9.
        preset(4, 32'hDEADBEEF);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, a);
        fb_transfer_request = 1'b0;
        neg_at(a + 1);
        check("rd1_a_lo", sram_a, 18'h00008);
        check("rd1_oe_n", sram_oe_n, 1'b0);
        neg_at(a + 2);
        check("rd1_a_hi", sram_a, 18'h00009);
        check("rd1_early_valid", fb_read_data_valid, 1'b0);
        neg_at(a + 3);
        check("rd1_valid", fb_read_data_valid, 1'b1);
        check("rd1_data", fb_read_data, 32'hDEADBEEF);
        neg_at(a + 4);
        check("rd1_pulse_end", fb_read_data_valid, 1'b0);
        check("rd1_hold", fb_read_data, 32'hDEADBEEF);
        step();

        // Four back-to-back reads with the request held high.
        preset(0, 32'h0123_4567);
        preset(1, 32'h89AB_CDEF);
        preset(2, 32'h0F1E_2D3C);
        preset(3, 32'h4B5A_6978);
        exp4 = '{32'h0123_4567, 32'h89AB_CDEF, 32'h0F1E_2D3C, 32'h4B5A_6978};
        vlog.delete();
        issue(1'b0, 32'h0, 32'h0, 4'h0, a0);
        issue(1'b0, 32'h4, 32'h0, 4'h0, a1);
        issue(1'b0, 32'h8, 32'h0, 4'h0, a2);
        issue(1'b0, 32'hC, 32'h0, 4'h0, a3);
        fb_transfer_request = 1'b0;
        check("b2b_gap1", a1 - a0, 2);
        check("b2b_gap2", a2 - a1, 2);
        check("b2b_gap3", a3 - a2, 2);
        neg_at(a3 + 4);
        check("b2b_count", vlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < vlog.size()) begin
                check("b2b_data", vlog[i].data, exp4[i]);
                check("b2b_slot", vlog[i].cyc - a0, 3 + 2 * i);
            end
        end
        step();

        // Partial-mask write followed immediately by a read of the same word.
        preset(8, 32'hAAAA_AAAA);
`ifdef FB_SRAM_WRITE_EN
        exp_wr = 32'hAA22_AA44;
`else
        exp_wr = 32'hAAAA_AAAA;
`endif
        issue(1'b1, 32'h20, 32'h1122_3344, 4'b0101, a);
        issue(1'b0, 32'h20, 32'h0, 4'h0, a);
        fb_transfer_request = 1'b0;
        neg_at(a + 3);
        check("wr_merge_valid", fb_read_data_valid, 1'b1);
        check("wr_merge_data", fb_read_data, exp_wr);
        step();

        // Empty mask leaves memory alone; full mask replaces the whole word.
        preset(12, 32'h5555_5555);
        preset(13, 32'h600D_F00D);
        issue(1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0000, a);
        issue(1'b1, 32'h34, 32'hCAFE_F00D, 4'b1111, a);
        issue(1'b0, 32'h30, 32'h0, 4'h0, a);
        fb_transfer_request = 1'b0;
        neg_at(a + 3);
        check("wr_mask0_data", fb_read_data, 32'h5555_5555);
        step();
`ifdef FB_SRAM_WRITE_EN
        exp_wr = 32'hCAFE_F00D;
`else
        exp_wr = 32'h600D_F00D;
`endif
        issue(1'b0, 32'h34, 32'h0, 4'h0, a);
        fb_transfer_request = 1'b0;
        neg_at(a + 3);
        check("wr_full_data", fb_read_data, exp_wr);
        step();

        // Reset one cycle after accepting a read: the read is abandoned.
        n0 = vlog.size();
        issue(1'b0, 32'h40, 32'h0, 4'h0, a);
        fb_transfer_request = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        neg_at(a + 2);
        check_reset_vals("mid_rd_rst");
        neg_at(a + 6);
        check("mid_rd_no_pulse", vlog.size(), n0);
        step();

        // Reset during the first half of a write: no strobe afterwards.
        issue(1'b1, 32'h50, 32'h1234_5678, 4'b0000, a);
        fb_transfer_request = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        neg_at(a + 2);
        check_reset_vals("mid_wr_rst");
        step();

        // Top word of the SRAM and an aliased high address.
        preset(32'h1FFFF, 32'h1357_9BDF);
        issue(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, a);
        fb_transfer_request = 1'b0;
        neg_at(a + 1);
        check("top_a_lo", sram_a, 18'h3FFFE);
        neg_at(a + 2);
        check("top_a_hi", sram_a, 18'h3FFFF);
        neg_at(a + 3);
        check("top_valid", fb_read_data_valid, 1'b1);
        check("top_data", fb_read_data, 32'h1357_9BDF);
        step();
        issue(1'b0, 32'h4000_0010, 32'h0, 4'h0, a);
        fb_transfer_request = 1'b0;
        neg_at(a + 1);
        check("alias_a_lo", sram_a, 18'h00008);
        neg_at(a + 3);
        check("alias_data", fb_read_data, 32'hDEADBEEF);
        step();

        repeat (4) step();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
